ingester_stripe_reader: RTL and testbench

Read side of the ingester's double-buffered stripe EBRs. After `hm01b0_ingester` completes an 8-line stripe in one of its two EBR banks, this block reads the 40 8×8 blocks back out of the finished bank in block-raster order. It streams them one pixel per beat over a valid/ready interface to the downstream JPEG DCT stage, while the ingester fills the other bank.

---
 rtl/ingester_stripe_reader.sv | 187 ++++++++++++++++++
 tb/tb_ingester_stripe_reader.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ingester_stripe_reader.sv
// ingester_stripe_reader
// Reads a finished stripe bank back out as 40 8x8 blocks in block-raster order
// and streams them one pixel per beat over valid/ready with sob/eob/eos flags.
// Optional build macro: INGESTER_READER_LEVEL_SHIFT_EN (pixel - 128, bit 7 inverted).
module ingester_stripe_reader #(
    parameter int unsigned NUM_EBRS       = 5,
    parameter int unsigned BLOCKS_PER_EBR = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       stripe_ready,
    input  logic       stripe_bank,
    output logic       ebr_bank,
    output logic [2:0] ebr_select,
    output logic [8:0] ebr_raddr,
    output logic       ebr_rclken,
    input  logic [7:0] ebr_rdata,
    output logic [7:0] out_pixel,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_sob,
    output logic       out_eob,
    output logic       out_eos,
    output logic       busy,
    output logic       overrun
);
    localparam logic [8:0] LAST_ADDR = 9'(BLOCKS_PER_EBR * 64 - 1);
    localparam logic [2:0] LAST_EBR  = 3'(NUM_EBRS - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_DRAIN} state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_bank;
    logic [2:0]  r_sel;
    logic [8:0]  r_addr;

    // Read issued last cycle; its data is on ebr_rdata this cycle.
    logic        r_inflight;
    logic        r_if_sob;
    logic        r_if_eob;
    logic        r_if_eos;

    // Two-entry skid buffer: r_out_* is the registered output slot, r_skid_* the overflow slot.
    // Data word layout: {pixel[7:0], sob, eob, eos}.
    logic        r_out_valid;
    logic [10:0] r_out_data;
    logic        r_skid_valid;
    logic [10:0] r_skid_data;

    logic        r_overrun;

    logic        w_pop;
    logic        w_issue;
    logic        w_busy;
    logic        w_last_read;
    logic        w_done;
    logic [1:0]  w_occ;
    logic [7:0]  w_cap_pix;
    logic [10:0] w_cap_data;

`ifdef INGESTER_READER_LEVEL_SHIFT_EN
    assign w_cap_pix = {~ebr_rdata[7], ebr_rdata[6:0]};
`else
    assign w_cap_pix = ebr_rdata;
`endif

    assign w_cap_data  = {w_cap_pix, r_if_sob, r_if_eob, r_if_eos};
    assign w_pop       = r_out_valid & out_ready;
    // Occupancy once this edge's pop is accounted for; counting the pop lets
    // a 2-entry buffer sustain one beat per cycle without ever overflowing.
    assign w_occ       = 2'(r_out_valid) + 2'(r_skid_valid) + 2'(r_inflight) - 2'(w_pop);
    assign w_last_read = (r_sel == LAST_EBR) && (r_addr == LAST_ADDR);
    assign w_done      = !r_inflight && !r_skid_valid && (!r_out_valid || w_pop);

    // State register
    always_ff @(posedge clock) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (stripe_ready)             w_state_nxt = ST_READ;
            ST_READ:  if (w_issue && w_last_read)   w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (w_done)                   w_state_nxt = ST_IDLE;
            default:                                w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs: busy and read issue gated by buffer credit
    always_comb begin
        w_busy  = 1'b0;
        w_issue = 1'b0;
        case (r_state)
            ST_READ: begin
                w_busy  = 1'b1;
                w_issue = (w_occ < 2'd2);
            end
            ST_DRAIN: w_busy = 1'b1;
            default: ;
        endcase
    end

    // Bank latch and read address counters (col/row/block in r_addr, EBR in r_sel)
    always_ff @(posedge clock) begin
        if (reset) begin
            r_bank <= 1'b0;
            r_sel  <= '0;
            r_addr <= '0;
        end else if (r_state == ST_IDLE && stripe_ready) begin
            r_bank <= stripe_bank;
            r_sel  <= '0;
            r_addr <= '0;
        end else if (w_issue && !w_last_read) begin
            r_addr <= (r_addr == LAST_ADDR) ? '0 : r_addr + 9'd1;
            if (r_addr == LAST_ADDR) r_sel <= r_sel + 3'd1;
        end
    end

    // Track the outstanding read and the flags that belong to it
    always_ff @(posedge clock) begin
        if (reset) begin
            r_inflight <= 1'b0;
            r_if_sob   <= 1'b0;
            r_if_eob   <= 1'b0;
            r_if_eos   <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            r_if_sob   <= (r_addr[5:0] == 6'd0);
            r_if_eob   <= (r_addr[5:0] == 6'd63);
            r_if_eos   <= w_last_read;
        end
    end

    // Skid buffer: capture returning data, keep order, hold output while stalled
    always_ff @(posedge clock) begin
        if (reset) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
        end else if (r_inflight) begin
            if (!r_out_valid || w_pop) begin
                if (r_skid_valid) begin
                    r_out_data  <= r_skid_data;
                    r_skid_data <= w_cap_data;
                end else begin
                    r_out_data  <= w_cap_data;
                end
                r_out_valid <= 1'b1;
            end else begin
                r_skid_data  <= w_cap_data;
                r_skid_valid <= 1'b1;
            end
        end else if (w_pop) begin
            if (r_skid_valid) begin
                r_out_data   <= r_skid_data;
                r_skid_valid <= 1'b0;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    // Sticky overrun: a stripe_ready while a stripe is still in progress
    always_ff @(posedge clock) begin
        if (reset)                      r_overrun <= 1'b0;
        else if (stripe_ready && w_busy) r_overrun <= 1'b1;
    end

    assign ebr_bank   = r_bank;
    assign ebr_select = r_sel;
    assign ebr_raddr  = r_addr;
    assign ebr_rclken = w_issue;
    assign out_valid  = r_out_valid;
    assign out_pixel  = r_out_data[10:3];
    assign out_sob    = r_out_data[2];
    assign out_eob    = r_out_data[1];
    assign out_eos    = r_out_data[0];
    assign busy       = w_busy;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_ingester_stripe_reader.sv
// Testbench for ingester_stripe_reader: EBR memory model, expected-beat queue
// built from block-raster arithmetic, randomized backpressure and corner sequences.
module tb_ingester_stripe_reader;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       stripe_ready = 1'b0;
    logic       stripe_bank = 1'b0;
    logic       out_ready = 1'b1;
    logic       ebr_bank;
    logic [2:0] ebr_select;
    logic [8:0] ebr_raddr;
    logic       ebr_rclken;
    logic [7:0] ebr_rdata = 8'h00;
    logic [7:0] out_pixel;
    logic       out_valid, out_sob, out_eob, out_eos, busy, overrun;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [7:0] pix;
        logic       sob;
        logic       eob;
        logic       eos;
    } beat_t;

    typedef struct {
        logic [7:0] din;
        logic [7:0] raw;
        logic [7:0] shifted;
    } ls_vec_t;

    logic [7:0] mem [0:9][0:511];
    beat_t      exp_q[$];
    logic [7:0] got_pix [0:7];
    ls_vec_t    tbl [0:3];

    int nbeats, nerr, nhold, nrd, first_e, last_e, fall_e, nsob, neos, nsel_bad;
    bit timed_out;

    always #5 clock = ~clock;

    ingester_stripe_reader #(.NUM_EBRS(5), .BLOCKS_PER_EBR(8)) dut (
        .clock(clock), .reset(reset),
        .stripe_ready(stripe_ready), .stripe_bank(stripe_bank),
        .ebr_bank(ebr_bank), .ebr_select(ebr_select), .ebr_raddr(ebr_raddr),
        .ebr_rclken(ebr_rclken), .ebr_rdata(ebr_rdata),
        .out_pixel(out_pixel), .out_valid(out_valid), .out_ready(out_ready),
        .out_sob(out_sob), .out_eob(out_eob), .out_eos(out_eos),
        .busy(busy), .overrun(overrun)
    );

    // Synchronous-read EBR bank model: data appears the cycle after rclken
    always @(posedge clock) begin
        if (ebr_rclken && ebr_select <= 3'd4)
            ebr_rdata <= mem[int'(ebr_bank) * 5 + int'(ebr_select)][ebr_raddr];
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic logic [7:0] model_pix(input logic [7:0] raw);
`ifdef INGESTER_READER_LEVEL_SHIFT_EN
        return 8'((int'(raw) - 128) & 255);
`else
        return raw;
`endif
    endfunction

    task automatic fill_formula();
        for (int e = 0; e < 10; e++)
            for (int a = 0; a < 512; a++)
                mem[e][a] = 8'((e * 64 + a) & 255);
    endtask

    task automatic fill_random();
        for (int e = 0; e < 10; e++)
            for (int a = 0; a < 512; a++)
                mem[e][a] = 8'($urandom_range(0, 255));
    endtask

    // Expected stream: blocks 0..39, row-major within each block
    task automatic build_expected(input bit bank);
        exp_q.delete();
        for (int b = 0; b < 40; b++)
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < 8; c++) begin
                    beat_t t;
                    t.pix = model_pix(mem[int'(bank) * 5 + b / 8][(b % 8) * 64 + r * 8 + c]);
                    t.sob = (r == 0 && c == 0);
                    t.eob = (r == 7 && c == 7);
                    t.eos = (r == 7 && c == 7 && b == 39);
                    exp_q.push_back(t);
                end
    endtask

    // Pulse stripe_ready (edge 0), then follow the stripe to completion.
    // e counts edges after edge 0; a beat seen in the loop transfers at edge e+1.
    task automatic run_stripe(input bit bank, input int pct, input int ov_at, input int rst_beat);
        beat_t cur, prev, et;
        bit    prev_stall;
        int    e;
        build_expected(bank);
        nbeats = 0; nerr = 0; nhold = 0; nrd = 0; first_e = -1; last_e = -1;
        fall_e = -1; nsob = 0; neos = 0; nsel_bad = 0; timed_out = 0;
        prev_stall = 0; prev = '0;
        stripe_bank  = bank;
        stripe_ready = 1'b1;
        @(posedge clock); #1;
        stripe_ready = 1'b0;
        stripe_bank  = ~bank;
        e = 0;
        while (busy) begin
            if (e > 20000) begin
                timed_out = 1;
                break;
            end
            out_ready    = ($urandom_range(0, 99) < pct);
            stripe_ready = (e == ov_at);
            if (rst_beat >= 0 && nbeats == rst_beat) begin
                reset = 1'b1;
                stripe_ready = 1'b0;
                @(posedge clock); #1;
                return;
            end
            #1;
            cur = {out_pixel, out_sob, out_eob, out_eos};
            if (prev_stall && (!out_valid || cur != prev)) nhold++;
            if (ebr_rclken) begin
                nrd++;
                if (ebr_select > 3'd4) nsel_bad++;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) nerr++;
                else begin
                    et = exp_q.pop_front();
                    if (cur != et) begin
                        nerr++;
                        if (nerr <= 4)
                            $display("bad beat %0d: got %h expected %h", nbeats, cur, et);
                    end
                end
                if (nbeats < 8) got_pix[nbeats] = out_pixel;
                if (first_e < 0) first_e = e + 1;
                last_e = e + 1;
                nbeats++;
                nsob += int'(out_sob);
                neos += int'(out_eos);
            end
            prev_stall = out_valid && !out_ready;
            prev = cur;
            @(posedge clock); #1;
            e++;
        end
        fall_e = e;
        stripe_ready = 1'b0;
    endtask

    initial begin
        int rc;
        logic [7:0] want;

        tbl[0] = '{din: 8'h00, raw: 8'h00, shifted: 8'h80};
        tbl[1] = '{din: 8'h80, raw: 8'h80, shifted: 8'h00};
        tbl[2] = '{din: 8'hFF, raw: 8'hFF, shifted: 8'h7F};
        tbl[3] = '{din: 8'h5A, raw: 8'h5A, shifted: 8'hDA};

        // Reset values
        fill_formula();
        reset = 1'b1; out_ready = 1'b1;
        rc = 0;
        repeat (3) begin
            @(posedge clock); #1;
            if (ebr_rclken) rc++;
        end
        chk("reset_rclken_activity", rc, 0);
        chk("reset_outputs", int'({ebr_bank, ebr_select, ebr_raddr, ebr_rclken, out_pixel,
                                   out_valid, out_sob, out_eob, out_eos, busy}), 0);
        chk("reset_overrun", int'(overrun), 0);
        reset = 1'b0;
        @(posedge clock); #1;

        // Full stripe, no backpressure, bank 1
        run_stripe(1'b1, 100, -1, -1);
        chk("full_timeout", int'(timed_out), 0);
        chk("full_ebr_bank", int'(ebr_bank), 1);
        chk("full_beats", nbeats, 2560);
        chk("full_data", nerr, 0);
        chk("full_first_edge", first_e, 3);
        chk("full_last_edge", last_e, 2562);
        chk("full_busy_fall_edge", fall_e, 2562);
        chk("full_reads", nrd, 2560);
        chk("full_sob_count", nsob, 40);
        chk("full_eos_count", neos, 1);
        chk("full_select_range", nsel_bad, 0);
        chk("full_overrun", int'(overrun), 0);

        // Random backpressure, bank 0
        fill_random();
        run_stripe(1'b0, 50, -1, -1);
        chk("bp_timeout", int'(timed_out), 0);
        chk("bp_beats", nbeats, 2560);
        chk("bp_data", nerr, 0);
        chk("bp_hold_while_stalled", nhold, 0);
        chk("bp_reads", nrd, 2560);
        chk("bp_busy", int'(busy), 0);

        // Overrun: second stripe_ready around cycle 100
        fill_random();
        run_stripe(1'b0, 100, 100, -1);
        chk("ovr_flag", int'(overrun), 1);
        chk("ovr_bank_kept", int'(ebr_bank), 0);
        chk("ovr_beats", nbeats, 2560);
        chk("ovr_data", nerr, 0);
        chk("ovr_last_edge", last_e, 2562);
        rc = 0;
        repeat (20) begin
            @(posedge clock); #1;
            if (ebr_rclken || out_valid || busy) rc++;
        end
        chk("ovr_no_second_stripe", rc, 0);
        chk("ovr_flag_sticky", int'(overrun), 1);

        // Mid-stripe reset at beat 1000, then restart
        run_stripe(1'b1, 100, -1, 1000);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_overrun_cleared", int'(overrun), 0);
        reset = 1'b0;
        rc = 0;
        repeat (5) begin
            @(posedge clock); #1;
            if (out_valid || ebr_rclken) rc++;
        end
        chk("rst_quiet_after", rc, 0);
        fill_random();
        run_stripe(1'b0, 100, -1, -1);
        chk("rst_restart_beats", nbeats, 2560);
        chk("rst_restart_data", nerr, 0);
        chk("rst_restart_first_edge", first_e, 3);

        // Pixel table: first four bytes of EBR 5 (bank 1), moderate backpressure
        fill_random();
        for (int i = 0; i < 4; i++) mem[5][i] = tbl[i].din;
        run_stripe(1'b1, 70, -1, -1);
        chk("tbl_data", nerr, 0);
        for (int i = 0; i < 4; i++) begin
`ifdef INGESTER_READER_LEVEL_SHIFT_EN
            want = tbl[i].shifted;
`else
            want = tbl[i].raw;
`endif
            chk($sformatf("tbl_pixel_%0d", i), int'(got_pix[i]), int'(want));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
